// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow input beats into one wide output word with lane keep bits
module stream_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_WIDTH-1:0]       in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [DATA_WIDTH*RATIO-1:0] out_data,
   output logic [RATIO-1:0]            out_keep,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready
);
   localparam int W  = DATA_WIDTH * RATIO;
   localparam int CW = $clog2(RATIO);

   logic [CW-1:0]    cnt_q = '0;
   logic [W-1:0]     acc_q = '0;
   logic [RATIO-1:0] keep_q = '0;
   logic [W-1:0]     out_data_q = '0;
   logic [RATIO-1:0] out_keep_q = '0;
   logic             out_last_q = 1'b0;
   logic             out_valid_q = 1'b0;

   logic [CW-1:0]    cnt_d;
   logic [W-1:0]     acc_d, out_data_d, merged_data;
   logic [RATIO-1:0] keep_d, out_keep_d, merged_keep;
   logic             out_last_d, out_valid_d, completing, in_hs;

   // next-state: lane write, word completion into the output stage, drain on output handshake
   always_comb begin
      completing  = (cnt_q == CW'(RATIO - 1)) || in_last;
      in_ready    = !reset && !(completing && out_valid_q && !out_ready);
      in_hs       = in_valid && in_ready;
      merged_data = acc_q | (W'(in_data) << (int'(cnt_q) * DATA_WIDTH));
      merged_keep = keep_q | (RATIO'(1) << cnt_q);
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      keep_d      = keep_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !out_ready;
      if (in_hs && completing) begin
         cnt_d       = '0;
         acc_d       = '0;
         keep_d      = '0;
         out_data_d  = merged_data;
         out_keep_d  = merged_keep;
         out_last_d  = in_last;
         out_valid_d = 1'b1;
      end else if (in_hs) begin
         cnt_d  = cnt_q + CW'(1);
         acc_d  = merged_data;
         keep_d = merged_keep;
      end
   end

   // state registers with synchronous reset clearing partial and pending words
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         keep_q      <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         keep_q      <= keep_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed and random stimulus checked against a queue-based packing model
module tb_stream_packer;
   localparam int DW = 8;
   localparam int R  = 4;
   localparam int W  = DW * R;

   typedef struct packed {
      logic [W-1:0] data;
      logic [R-1:0] keep;
      logic         last;
   } word_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data;
   logic          in_valid, in_last, in_ready;
   logic [W-1:0]  out_data;
   logic [R-1:0]  out_keep;
   logic          out_last, out_valid, out_ready;

   int total = 0;
   int bad = 0;
   int words_out = 0;
   logic [DW-1:0] beats[$];
   word_t exp_q[$];

   stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // a word is just the accepted beats laid out lowest-first, keep marking how many arrived
   function automatic void push_word(input logic last);
      word_t w = '0;
      foreach (beats[i]) begin
         w.data[i*DW +: DW] = beats[i];
         w.keep[i] = 1'b1;
      end
      w.last = last;
      exp_q.push_back(w);
      beats.delete();
   endfunction

   task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic ordy,
                       output logic acc);
      logic ihs, ohs, comp;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      @(negedge clk);
      comp = (beats.size() == R - 1) || l;
      chk("in_ready", in_ready, !(comp && exp_q.size() > 0 && !ordy));
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("out_data", out_data, exp_q[0].data);
         chk("out_keep", out_keep, exp_q[0].keep);
         chk("out_last", out_last, exp_q[0].last);
      end
      ihs = v && in_ready;
      ohs = out_valid && ordy;
      acc = ihs;
      @(posedge clk);
      #1;
      if (ohs && exp_q.size() > 0) begin
         exp_q.delete(0);
         words_out++;
      end
      if (ihs) begin
         beats.push_back(d);
         if (beats.size() == R || l) push_word(l);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         in_valid  = 1'($urandom);
         in_last   = 1'($urandom);
         in_data   = DW'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_keep", out_keep, 0);
      chk("rst_out_last", out_last, 0);
      beats.delete();
      exp_q.delete();
   endtask

   initial begin
      logic a;
      int stalls, w0;
      in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
      do_reset(2);
      // four full beats
      for (int i = 1; i <= 4; i++) step(1, DW'(i * 'h11), 0, 1, a);
      chk("full_data", out_data, 32'h44332211);
      chk("full_keep", out_keep, 4'hF);
      chk("full_last", out_last, 0);
      chk("full_valid", out_valid, 1);
      // short packet, then the next one restarts at lane 0
      step(1, 8'hAA, 0, 1, a);
      step(1, 8'hBB, 1, 1, a);
      chk("short_data", out_data, 32'h0000BBAA);
      chk("short_keep", out_keep, 4'h3);
      chk("short_last", out_last, 1);
      step(1, 8'hCC, 0, 1, a);
      step(1, 8'hDD, 1, 1, a);
      chk("lane0_data", out_data, 32'h0000DDCC);
      // stalled output stage
      step(0, 0, 0, 1, a);
      for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0, a);
      for (int i = 5; i <= 7; i++) begin
         step(1, DW'(i), 0, 0, a);
         chk("stall_accept", a, 1);
         chk("stall_hold", out_data, 32'h04030201);
      end
      for (int k = 0; k < 3; k++) begin
         step(1, 8'h08, 0, 0, a);
         chk("stall_block", a, 0);
         chk("stall_hold4", out_data, 32'h04030201);
      end
      step(1, 8'h08, 0, 1, a);
      chk("stall_release", a, 1);
      chk("stall_next", out_data, 32'h08070605);
      // reset mid-word discards residue
      step(0, 0, 0, 1, a);
      step(1, 8'hEE, 0, 1, a);
      step(1, 8'hFF, 0, 1, a);
      do_reset(1);
      for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 1, a);
      chk("rst_clean_data", out_data, 32'h04030201);
      chk("rst_clean_keep", out_keep, 4'hF);
      // sustained throughput
      step(0, 0, 0, 1, a);
      w0 = words_out;
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, DW'($urandom), 0, 1, a);
         if (!a) stalls++;
      end
      step(0, 0, 0, 1, a);
      chk("stream_stalls", stalls, 0);
      chk("stream_words", words_out - w0, 4);
      // random traffic with one reset in the middle
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset(1 + int'($urandom_range(2)));
         step($urandom_range(9) < 7, DW'($urandom), $urandom_range(4) == 0,
              $urandom_range(9) < 6, a);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, a);
      chk("drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the input beat width in bits; legal values are multiples of 8.
REQ-002 Parameter RATIO, default 4, SHALL set the number of input beats packed per output word; legal range is 2..16.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port in_data  input  DATA_WIDTH  SHALL carry the input beat payload.
REQ-006 Port in_valid  input  1  SHALL indicate that the upstream in_data is valid.
REQ-007 Port in_last  input  1  SHALL mark the final beat of a packet.
REQ-008 Port in_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-009 Port out_data  output  DATA_WIDTH*RATIO  SHALL carry the packed word.
REQ-010 Port out_keep  output  RATIO  SHALL give one bit per lane; 1 means the lane holds a received beat.
REQ-011 Port out_last  output  1  SHALL mark the word that contains an in_last beat.
REQ-012 Port out_valid  output  1  SHALL indicate that the out_* signals are valid.
REQ-013 Port out_ready  input  1  SHALL indicate that downstream accepts the word this cycle.

Function
REQ-014 An input handshake SHALL occur when in_valid && in_ready, and an output handshake when out_valid && out_ready, both sampled at the clk edge.
REQ-015 The block SHALL hold a lane counter (0..RATIO-1), an accumulator (DATA_WIDTH*RATIO data bits plus RATIO keep bits) and a registered output stage.
REQ-016 On an input handshake, the block SHALL write in_data to accumulator lane[counter] (lane 0 = bits DATA_WIDTH-1:0, first beat lowest), set keep[counter], and increment the counter.
REQ-017 A beat SHALL be "completing" when counter==RATIO-1 or in_last==1.
REQ-018 On a completing handshake, the block SHALL, on the next edge, load the output stage with the accumulator contents merged with the current beat, set out_last=in_last, set out_valid=1, zero the accumulator and keep, and reset the counter to 0.
REQ-019 In a partial word, lanes not written SHALL read as zero in out_data, and the corresponding out_keep bits SHALL be 0.
REQ-020 in_ready SHALL be 1 unless the presented beat is completing, out_valid==1 and out_ready==0; the combinational path out_ready->in_ready is permitted.
REQ-021 Non-completing beats SHALL be accepted while the output stage is stalled.
REQ-022 While out_valid==1 and out_ready==0, out_data, out_keep and out_last SHALL remain stable, and out_valid SHALL stay at 1.
REQ-023 On an output handshake with no completing input handshake in the same cycle, out_valid SHALL go to 0 on the next edge.
REQ-024 A simultaneous output handshake and completing input handshake SHALL reload the output stage, so that sustained throughput is one word per RATIO input beats with no bubbles.
REQ-025 Latency SHALL be exactly 1 cycle from the completing input handshake to out_valid==1.
REQ-026 An in_last beat arriving at counter==RATIO-1 SHALL produce a full word with out_keep all-ones and out_last=1.
REQ-027 The block SHALL never drop, duplicate or reorder beats.
REQ-028 out_valid SHALL never rise before at least one input handshake has occurred since reset.

Reset
REQ-029 While reset==1 at a clk edge, the block SHALL set out_valid=0, out_data=0, out_keep=0, out_last=0, counter=0, and accumulator data and keep to 0.
REQ-030 During reset, in_ready SHALL be 0, and no handshake SHALL be recorded.
REQ-031 A reset asserted mid-word SHALL discard all partial beats and any pending output word.
REQ-032 The block SHALL also reach the reset state through register initial values, for formal runs that start without reset.

Verification (DATA_WIDTH=8, RATIO=4)
REQ-033 Input beats 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> one cycle after the 4th handshake: out_data=0x44332211, out_keep=0xF, out_last=0.
REQ-034 Input beats 0xAA, then 0xBB with in_last=1 -> out_data=0x0000BBAA, out_keep=0x3, out_last=1; the next beat lands in lane 0.
REQ-035 Hold out_ready=0 with a word pending, then send 4 beats -> beats 1-3 are accepted, in_ready=0 on beat 4 until out_ready=1, and out_data is held stable throughout.
REQ-036 Send 2 beats, assert reset for 1 cycle, then send 0x01..0x04 -> out_data=0x04030201, out_keep=0xF, with no residue from before reset.
REQ-037 Send 16 back-to-back beats with out_ready=1 -> 4 words on consecutive 4-cycle intervals, and in_ready never 0.
REQ-038 The formal harness SHALL prove AXI-Stream stability (REQ-022), the ordering of any arbitrary n-th beat to lane n mod RATIO, and REQ-028.
